// File: rtl/dev_bridge.sv
// dev_bridge: CPU-side bridge that routes each request either to a flat
// memory port or to one of NUM_DEV peripheral channels. Requests to a
// peripheral that is slow to answer are ended by a wait counter. Raw device
// interrupts are registered onto irq_pend. All outputs are registered.
module dev_bridge #(
  parameter int          NUM_DEV  = 2,
  parameter logic [31:0] DEV_BASE = 32'h0000_7F00,
  parameter logic [31:0] DEV_SPAN = 32'h10,
  parameter int          TIMEOUT  = 15
) (
  input  logic                   clk,
  input  logic                   reset_n,
  // CPU side
  input  logic                   cpu_req,
  input  logic [31:0]            cpu_addr,
  input  logic [31:0]            cpu_wdata,
  input  logic [3:0]             cpu_byteen,
  output logic [31:0]            cpu_rdata,
  output logic                   cpu_ready,
  output logic                   cpu_err,
  // memory side
  output logic [31:0]            mem_addr,
  output logic [31:0]            mem_wdata,
  output logic [3:0]             mem_byteen,
  input  logic [31:0]            mem_rdata,
  // peripheral side
  output logic [31:0]            dev_addr,
  output logic [31:0]            dev_wdata,
  output logic [NUM_DEV-1:0]     dev_sel,
  output logic [NUM_DEV-1:0]     dev_we,
  input  logic [NUM_DEV*32-1:0]  dev_rdata,
  input  logic [NUM_DEV-1:0]     dev_ready,
  // interrupts
  input  logic [NUM_DEV-1:0]     irq_in,
  output logic [NUM_DEV-1:0]     irq_pend
);

  localparam int IDX_W = (NUM_DEV > 1) ? $clog2(NUM_DEV) : 1;
  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MEM  = 2'd1,
    DEV  = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t             state_reg;
  logic [IDX_W-1:0]   idx_reg;        // channel being served in DEV
  logic               dev_wr_reg;     // current device access is a write
  logic [7:0]         wait_cnt_reg;   // DEV cycles spent without dev_ready
  logic               mem_phase_reg;  // 0: address cycle, 1: data-return cycle

  // Per-channel address window decode on the live CPU address.
  logic [NUM_DEV-1:0] hit_vec;
  logic [32:0]        addr_ext;

  assign addr_ext = {1'b0, cpu_addr};

  generate
    for (genvar gi = 0; gi < NUM_DEV; gi++) begin : g_win
      localparam logic [32:0] WIN_LO = 33'(DEV_BASE) + 33'(gi) * 33'(DEV_SPAN);
      localparam logic [32:0] WIN_HI = WIN_LO + 33'(DEV_SPAN);
      assign hit_vec[gi] = (addr_ext >= WIN_LO) && (addr_ext < WIN_HI);
    end
  endgenerate

  logic             hit_any;
  logic [IDX_W-1:0] hit_idx;
  logic             bad_align;
  logic             bad_width;

  // Encode the (disjoint) window hits into a channel index.
  always_comb begin
    hit_any = |hit_vec;
    hit_idx = '0;
    for (int i = 0; i < NUM_DEV; i++) begin
      if (hit_vec[i]) begin
        hit_idx = IDX_W'(i);
      end
    end
  end

  assign bad_align = (cpu_addr[1:0] != 2'b00);
  assign bad_width = (cpu_byteen != 4'h0) && (cpu_byteen != 4'hF);

  // Response inputs of the channel currently being served.
  logic        cur_ready;
  logic [31:0] cur_rdata;
  logic [7:0]  wait_inc;

  assign cur_ready = dev_ready[idx_reg];
  assign cur_rdata = dev_rdata[32*idx_reg +: 32];
  assign wait_inc  = wait_cnt_reg + 8'd1;

  // Interrupt inputs are simply registered, regardless of bridge activity.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_pend <= '0;
    end else begin
      irq_pend <= irq_in;
    end
  end

  // Transaction FSM with all bus outputs registered alongside the state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      idx_reg       <= '0;
      dev_wr_reg    <= 1'b0;
      wait_cnt_reg  <= 8'd0;
      mem_phase_reg <= 1'b0;
      cpu_rdata     <= 32'd0;
      cpu_ready     <= 1'b0;
      cpu_err       <= 1'b0;
      mem_addr      <= 32'd0;
      mem_wdata     <= 32'd0;
      mem_byteen    <= 4'd0;
      dev_addr      <= 32'd0;
      dev_wdata     <= 32'd0;
      dev_sel       <= '0;
      dev_we        <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (cpu_req) begin
            mem_addr  <= cpu_addr;
            mem_wdata <= cpu_wdata;
            dev_addr  <= cpu_addr;
            dev_wdata <= cpu_wdata;
            if (bad_align || (hit_any && bad_width)) begin
              // Rejected without touching either bus.
              cpu_rdata <= 32'd0;
              cpu_err   <= 1'b1;
              cpu_ready <= 1'b1;
              state_reg <= RESP;
            end else if (hit_any) begin
              idx_reg      <= hit_idx;
              dev_wr_reg   <= |cpu_byteen;
              wait_cnt_reg <= 8'd0;
              dev_sel      <= hit_vec;
              dev_we       <= (|cpu_byteen) ? hit_vec : '0;
              state_reg    <= DEV;
            end else begin
              mem_byteen    <= cpu_byteen;
              mem_phase_reg <= 1'b0;
              state_reg     <= MEM;
            end
          end
        end

        MEM: begin
          // The address/strobe cycle is followed by a quiet cycle in which
          // memory returns the read data, captured at its end.
          if (!mem_phase_reg) begin
            mem_byteen    <= 4'd0;
            mem_phase_reg <= 1'b1;
          end else begin
            mem_phase_reg <= 1'b0;
            cpu_rdata     <= mem_rdata;
            cpu_err       <= 1'b0;
            cpu_ready     <= 1'b1;
            state_reg     <= RESP;
          end
        end

        DEV: begin
          // A ready on the same cycle the counter expires still succeeds.
          if (cur_ready) begin
            cpu_rdata <= dev_wr_reg ? 32'd0 : cur_rdata;
            cpu_err   <= 1'b0;
            cpu_ready <= 1'b1;
            dev_sel   <= '0;
            dev_we    <= '0;
            state_reg <= RESP;
          end else if (wait_inc == TIMEOUT_C) begin
            wait_cnt_reg <= wait_inc;
            cpu_rdata    <= 32'd0;
            cpu_err      <= 1'b1;
            cpu_ready    <= 1'b1;
            dev_sel      <= '0;
            dev_we       <= '0;
            state_reg    <= RESP;
          end else begin
            wait_cnt_reg <= wait_inc;
          end
        end

        RESP: begin
          cpu_ready <= 1'b0;
          cpu_err   <= 1'b0;
          state_reg <= IDLE;
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dev_bridge.sv
// Directed bench for dev_bridge: a vector table of single transactions plus
// hand-written sequences for reset, interrupts and reset mid-transaction.
module tb_dev_bridge;

  logic        clk;
  logic        reset_n;
  logic        cpu_req;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [3:0]  cpu_byteen;
  logic [31:0] cpu_rdata;
  logic        cpu_ready;
  logic        cpu_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_byteen;
  logic [31:0] mem_rdata;
  logic [31:0] dev_addr;
  logic [31:0] dev_wdata;
  logic [1:0]  dev_sel;
  logic [1:0]  dev_we;
  logic [63:0] dev_rdata;
  logic [1:0]  dev_ready;
  logic [1:0]  irq_in;
  logic [1:0]  irq_pend;

  int n_tests;
  int n_fail;

  dev_bridge dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cpu_req    (cpu_req),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_byteen (cpu_byteen),
    .cpu_rdata  (cpu_rdata),
    .cpu_ready  (cpu_ready),
    .cpu_err    (cpu_err),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_byteen (mem_byteen),
    .mem_rdata  (mem_rdata),
    .dev_addr   (dev_addr),
    .dev_wdata  (dev_wdata),
    .dev_sel    (dev_sel),
    .dev_we     (dev_we),
    .dev_rdata  (dev_rdata),
    .dev_ready  (dev_ready),
    .irq_in     (irq_in),
    .irq_pend   (irq_pend)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: data for the address presented is returned the next cycle.
  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return (a == 32'h0000_1000) ? 32'hDEAD_BEEF : (a ^ 32'h5A5A_0000);
  endfunction

  always @(posedge clk) mem_rdata <= mem_val(mem_addr);

  // Fixed device read data: channel 1 in the upper word, channel 0 lower.
  assign dev_rdata = {32'hB1B1_0001, 32'hA0A0_0000};

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  byteen;
    int          ready_after;  // waits before dev_ready; -1 never
    bit          noise;        // raise unselected channel's ready while waiting
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;      // cycles from request to cpu_ready
    int          exp_sel_cyc;
    logic [1:0]  exp_sel;
    logic [1:0]  exp_we;
    logic [3:0]  exp_mem_be;
  } txn_t;

  txn_t vec [0:11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Issue one request from vector k and check everything it produces.
  task automatic run_txn(input int k);
    txn_t        v;
    int          lat;
    int          sel_cyc;
    int          mem_cyc;
    logic [1:0]  sel_or;
    logic [1:0]  we_or;
    logic [3:0]  be_or;
    logic [31:0] rd;
    logic        er;
    v       = vec[k];
    lat     = 0;
    sel_cyc = 0;
    mem_cyc = 0;
    sel_or  = 2'b00;
    we_or   = 2'b00;
    be_or   = 4'h0;
    rd      = 32'hXXXX_XXXX;
    er      = 1'bx;
    cpu_req    = 1'b1;
    cpu_addr   = v.addr;
    cpu_wdata  = v.wdata;
    cpu_byteen = v.byteen;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(posedge clk);
      #1;
      if (mem_byteen != 4'h0) begin
        mem_cyc++;
        be_or |= mem_byteen;
      end
      if (cpu_ready) begin
        lat       = cyc;
        rd        = cpu_rdata;
        er        = cpu_err;
        cpu_req   = 1'b0;
        dev_ready = 2'b00;
        break;
      end
      if (dev_sel != 2'b00) begin
        sel_cyc++;
        sel_or |= dev_sel;
        we_or  |= dev_we;
        if (sel_cyc == 1) begin
          check($sformatf("t%0d_dev_addr", k), dev_addr, v.addr);
          check($sformatf("t%0d_dev_wdata", k), dev_wdata, v.wdata);
        end
        if (v.ready_after >= 0 && sel_cyc == v.ready_after + 1)
          dev_ready = dev_sel;
        else
          dev_ready = v.noise ? ~dev_sel : 2'b00;
      end else begin
        dev_ready = 2'b00;
      end
    end
    cpu_req = 1'b0;
    check($sformatf("t%0d_latency", k), 32'(lat), 32'(v.exp_lat));
    check($sformatf("t%0d_rdata", k), rd, v.exp_rdata);
    check($sformatf("t%0d_err", k), {31'd0, er}, {31'd0, v.exp_err});
    check($sformatf("t%0d_sel_cycles", k), 32'(sel_cyc), 32'(v.exp_sel_cyc));
    check($sformatf("t%0d_sel", k), {30'd0, sel_or}, {30'd0, v.exp_sel});
    check($sformatf("t%0d_we", k), {30'd0, we_or}, {30'd0, v.exp_we});
    check($sformatf("t%0d_mem_be", k), {28'd0, be_or}, {28'd0, v.exp_mem_be});
    check($sformatf("t%0d_mem_cycles", k), 32'(mem_cyc), (v.exp_mem_be != 4'h0) ? 32'd1 : 32'd0);
    // One cycle later the pulse is gone and the read data is held.
    @(posedge clk);
    #1;
    check($sformatf("t%0d_ready_drop", k), {31'd0, cpu_ready}, 32'd0);
    check($sformatf("t%0d_err_drop", k), {31'd0, cpu_err}, 32'd0);
    check($sformatf("t%0d_rdata_hold", k), cpu_rdata, v.exp_rdata);
    $display("[TB] txn %0d addr=%h be=%h lat=%0d rdata=%h err=%0d sel_cyc=%0d",
             k, v.addr, v.byteen, lat, rd, er, sel_cyc);
  endtask

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    reset_n    = 1'b0;
    cpu_req    = 1'b0;
    cpu_addr   = 32'd0;
    cpu_wdata  = 32'd0;
    cpu_byteen = 4'h0;
    dev_ready  = 2'b00;
    irq_in     = 2'b11;

    //          addr           wdata          be    rdy nz exp_rdata      err lat sel  sel    we     mem_be
    vec[0]  = '{32'h0000_1000, 32'h0,        4'h0, -1, 0, 32'hDEAD_BEEF, 0,  3,  0, 2'b00, 2'b00, 4'h0};
    vec[1]  = '{32'h0000_3000, 32'h1234,     4'hF, -1, 0, 32'h5A5A_3000, 0,  3,  0, 2'b00, 2'b00, 4'hF};
    vec[2]  = '{32'h0000_7F14, 32'h5,        4'hF,  2, 0, 32'h0,         0,  4,  3, 2'b10, 2'b10, 4'h0};
    vec[3]  = '{32'h0000_7F04, 32'h0,        4'h0, -1, 1, 32'h0,         1, 16, 15, 2'b01, 2'b00, 4'h0};
    vec[4]  = '{32'h0000_7F00, 32'h77,       4'h3, -1, 0, 32'h0,         1,  1,  0, 2'b00, 2'b00, 4'h0};
    vec[5]  = '{32'h0000_1002, 32'h0,        4'h0, -1, 0, 32'h0,         1,  1,  0, 2'b00, 2'b00, 4'h0};
    vec[6]  = '{32'h0000_7F1C, 32'h0,        4'h0,  0, 1, 32'hB1B1_0001, 0,  2,  1, 2'b10, 2'b00, 4'h0};
    vec[7]  = '{32'h0000_7F08, 32'h0,        4'h0, 14, 0, 32'hA0A0_0000, 0, 16, 15, 2'b01, 2'b00, 4'h0};
    vec[8]  = '{32'h0000_7F0C, 32'h0,        4'h0, 13, 0, 32'hA0A0_0000, 0, 15, 14, 2'b01, 2'b00, 4'h0};
    vec[9]  = '{32'h0000_7F20, 32'h99,       4'h3, -1, 0, 32'h5A5A_7F20, 0,  3,  0, 2'b00, 2'b00, 4'h3};
    vec[10] = '{32'h0000_7EFC, 32'h0,        4'h0, -1, 0, 32'h5A5A_7EFC, 0,  3,  0, 2'b00, 2'b00, 4'h0};
    vec[11] = '{32'h0000_2000, 32'h0,        4'h0, -1, 0, 32'h5A5A_2000, 0,  3,  0, 2'b00, 2'b00, 4'h0};

    // Reset state, with interrupts asserted to show they are held off.
    repeat (2) @(posedge clk);
    #1;
    check("rst_cpu_ready", {31'd0, cpu_ready}, 32'd0);
    check("rst_cpu_err", {31'd0, cpu_err}, 32'd0);
    check("rst_cpu_rdata", cpu_rdata, 32'd0);
    check("rst_mem_byteen", {28'd0, mem_byteen}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_dev_sel", {30'd0, dev_sel}, 32'd0);
    check("rst_dev_we", {30'd0, dev_we}, 32'd0);
    check("rst_irq_pend", {30'd0, irq_pend}, 32'd0);
    irq_in  = 2'b00;
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Interrupt pulse shows up exactly one cycle later, for one cycle.
    irq_in = 2'b01;
    check("irq_before", {30'd0, irq_pend}, 32'd0);
    @(posedge clk);
    #1;
    irq_in = 2'b00;
    check("irq_pend_set", {30'd0, irq_pend}, 32'd1);
    @(posedge clk);
    #1;
    check("irq_pend_clr", {30'd0, irq_pend}, 32'd0);
    $display("[TB] irq pulse 01 checked");

    for (int k = 0; k <= 10; k++) begin
      run_txn(k);
    end

    // Reset while a device read is waiting: abandoned with no pulse.
    cpu_req    = 1'b1;
    cpu_addr   = 32'h0000_7F04;
    cpu_wdata  = 32'd0;
    cpu_byteen = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    check("mid_dev_sel_before", {30'd0, dev_sel}, 32'd1);
    reset_n = 1'b0;
    cpu_req = 1'b0;
    #1;
    check("mid_dev_sel_rst", {30'd0, dev_sel}, 32'd0);
    check("mid_ready_rst", {31'd0, cpu_ready}, 32'd0);
    check("mid_rdata_rst", cpu_rdata, 32'd0);
    for (int c = 0; c < 2; c++) begin
      @(posedge clk);
      #1;
      check("mid_ready_held", {31'd0, cpu_ready}, 32'd0);
    end
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("mid_ready_after_rel", {31'd0, cpu_ready}, 32'd0);
    $display("[TB] reset during device wait checked");
    run_txn(11);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
